// File: rtl/vga_timing_gen_if.sv
// vga_timing_gen_if: video timing bundle from the raster generator to the
// frame-buffer reader and pixel mux.
//   master : driven by vga_timing_gen
//   slave  : consumed by downstream video logic
// Signals:
//   hsync, vsync         sync levels (polarity applied by the generator)
//   display_en, x, y     visible-area flag and current coordinates
//   line_start           one-clk pulse on the first pixel of each visible line
//   frame_start          one-clk pulse on pixel (0,0)
//   fetch_en, fetch_x/y  look-ahead position for the framebuffer read path
interface vga_timing_gen_if #(
  parameter int CW = 11
);
  logic          hsync;
  logic          vsync;
  logic          display_en;
  logic [CW-1:0] x;
  logic [CW-1:0] y;
  logic          line_start;
  logic          frame_start;
  logic          fetch_en;
  logic [CW-1:0] fetch_x;
  logic [CW-1:0] fetch_y;

  modport master (
    output hsync, vsync, display_en, x, y,
    output line_start, frame_start,
    output fetch_en, fetch_x, fetch_y
  );

  modport slave (
    input hsync, vsync, display_en, x, y,
    input line_start, frame_start,
    input fetch_en, fetch_x, fetch_y
  );
endinterface

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised raster timing generator.
// Walks a horizontal/vertical counter pair on each pixel tick and produces
// registered sync, visible-area, coordinate, strobe and look-ahead fetch
// outputs, all one clk behind the counter value they describe.
// Ports:
//   clk     system or pixel clock
//   rst_n   asynchronous active-low reset
//   pix_ce  pixel tick enable (tie high when clk is the pixel clock)
//   vid     timing bundle (master side), see vga_timing_gen_if
//
// Phase FSM (one instance for H, one for V):
//   state     | meaning
//   PH_ACTIVE | counter inside the visible area
//   PH_FRONT  | front porch
//   PH_SYNC   | sync pulse asserted
//   PH_BACK   | back porch
module vga_timing_gen #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter bit HSYNC_POL = 1'b0,
  parameter bit VSYNC_POL = 1'b0,
  parameter int LOOKAHEAD = 2,
  parameter int CW        = 11
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pix_ce,
  vga_timing_gen_if.master vid
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [CW-1:0] H_LAST     = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] H_VIS_C    = CW'(H_VISIBLE);
  localparam logic [CW-1:0] H_SYNC_BEG = CW'(H_VISIBLE + H_FRONT);
  localparam logic [CW-1:0] H_BACK_BEG = CW'(H_VISIBLE + H_FRONT + H_SYNC);

  localparam logic [CW-1:0] V_LAST     = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] V_VIS_C    = CW'(V_VISIBLE);
  localparam logic [CW-1:0] V_SYNC_BEG = CW'(V_VISIBLE + V_FRONT);
  localparam logic [CW-1:0] V_BACK_BEG = CW'(V_VISIBLE + V_FRONT + V_SYNC);

  // One extra bit so h_cnt + LOOKAHEAD cannot overflow before the wrap test.
  localparam logic [CW:0] LA_C      = (CW+1)'(LOOKAHEAD);
  localparam logic [CW:0] H_TOTAL_W = (CW+1)'(H_TOTAL);

  typedef enum logic [1:0] {
    PH_ACTIVE = 2'd0,
    PH_FRONT  = 2'd1,
    PH_SYNC   = 2'd2,
    PH_BACK   = 2'd3
  } phase_t;

  // Phase for the counter value about to be loaded. Later boundaries are
  // tested first so a zero-width porch collapses into the following phase.
  function automatic phase_t phase_at(
    input logic [CW-1:0] cnt,
    input logic [CW-1:0] vis,
    input logic [CW-1:0] sync_beg,
    input logic [CW-1:0] back_beg,
    input phase_t        cur
  );
    phase_t ph;
    ph = cur;
    if (cnt == back_beg)      ph = PH_BACK;
    else if (cnt == sync_beg) ph = PH_SYNC;
    else if (cnt == vis)      ph = PH_FRONT;
    else if (cnt == '0)       ph = PH_ACTIVE;
    return ph;
  endfunction

  logic [CW-1:0] h_cnt, h_cnt_nxt;
  logic [CW-1:0] v_cnt, v_cnt_nxt;
  logic [CW-1:0] v_inc;
  logic          h_wrap;
  phase_t        h_state, h_state_nxt;
  phase_t        v_state, v_state_nxt;

  // counters and phase next-state
  always_comb begin
    h_wrap      = (h_cnt == H_LAST);
    h_cnt_nxt   = h_wrap ? '0 : h_cnt + 1'b1;
    v_inc       = (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
    v_cnt_nxt   = v_cnt;
    v_state_nxt = v_state;
    h_state_nxt = phase_at(h_cnt_nxt, H_VIS_C, H_SYNC_BEG, H_BACK_BEG, h_state);
    if (h_wrap) begin
      v_cnt_nxt   = v_inc;
      v_state_nxt = phase_at(v_inc, V_VIS_C, V_SYNC_BEG, V_BACK_BEG, v_state);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt   <= '0;
      v_cnt   <= '0;
      h_state <= PH_ACTIVE;
      v_state <= PH_ACTIVE;
    end else if (pix_ce) begin
      h_cnt   <= h_cnt_nxt;
      v_cnt   <= v_cnt_nxt;
      h_state <= h_state_nxt;
      v_state <= v_state_nxt;
    end
  end

  // look-ahead position; crossing the line end moves to the next row
  logic [CW:0]   ha_sum;
  logic [CW-1:0] fa_x, fa_y;
  logic          fa_en;

  always_comb begin
    ha_sum = {1'b0, h_cnt} + LA_C;
    fa_x   = CW'(ha_sum);
    fa_y   = v_cnt;
    if (ha_sum >= H_TOTAL_W) begin
      fa_x = CW'(ha_sum - H_TOTAL_W);
      fa_y = v_inc;
    end
    fa_en = (fa_x < H_VIS_C) && (fa_y < V_VIS_C);
  end

  // values presented on the next pixel tick
  logic de_d, hsync_d, vsync_d, ls_d, fs_d;

  always_comb begin
    de_d    = (h_state == PH_ACTIVE) && (v_state == PH_ACTIVE);
    hsync_d = (h_state == PH_SYNC) ? HSYNC_POL : ~HSYNC_POL;
    vsync_d = (v_state == PH_SYNC) ? VSYNC_POL : ~VSYNC_POL;
    ls_d    = (h_cnt == '0) && (v_cnt < V_VIS_C);
    fs_d    = (h_cnt == '0) && (v_cnt == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vid.hsync       <= ~HSYNC_POL;
      vid.vsync       <= ~VSYNC_POL;
      vid.display_en  <= 1'b0;
      vid.x           <= '0;
      vid.y           <= '0;
      vid.line_start  <= 1'b0;
      vid.frame_start <= 1'b0;
      vid.fetch_en    <= 1'b0;
      vid.fetch_x     <= '0;
      vid.fetch_y     <= '0;
    end else begin
      // strobes last one clk even when pix_ce stays low afterwards
      vid.line_start  <= 1'b0;
      vid.frame_start <= 1'b0;
      if (pix_ce) begin
        vid.hsync       <= hsync_d;
        vid.vsync       <= vsync_d;
        vid.display_en  <= de_d;
        vid.x           <= de_d ? h_cnt : '0;
        vid.y           <= de_d ? v_cnt : '0;
        vid.line_start  <= ls_d;
        vid.frame_start <= fs_d;
        vid.fetch_en    <= fa_en;
        vid.fetch_x     <= fa_en ? fa_x : '0;
        vid.fetch_y     <= fa_en ? fa_y : '0;
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
module tb_vga_timing_gen;

  localparam int CW  = 5;
  localparam int HV  = 8;
  localparam int HF  = 2;
  localparam int HS  = 3;
  localparam int HB  = 3;
  localparam int VV  = 4;
  localparam int VF  = 1;
  localparam int VS  = 2;
  localparam int VB  = 1;
  localparam int HT  = HV + HF + HS + HB;  // 16
  localparam int VT  = VV + VF + VS + VB;  // 8

  logic clk;
  logic rst_n;
  logic pix_ce;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  vga_timing_gen_if #(.CW(CW)) vid_a ();
  vga_timing_gen_if #(.CW(CW)) vid_b ();

  // a: active-low syncs, two-tick look-ahead
  vga_timing_gen #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .LOOKAHEAD(2), .CW(CW)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .pix_ce(pix_ce), .vid(vid_a)
  );

  // b: active-high syncs, no look-ahead
  vga_timing_gen #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .LOOKAHEAD(0), .CW(CW)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .pix_ce(pix_ce), .vid(vid_b)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  // reference raster position and expected registered outputs
  int   mh, mv, e_ph, e_pv;
  logic e_de, e_hs, e_vs, e_ls, e_fs, e_fen;
  int   e_x, e_y, e_fx, e_fy;

  // pulse-width / period measurements on dut_a
  bit   meas_on;
  int   meas_div;
  bit   ls_seen, hs_seen, vs_seen, fs_seen;
  int   ls_cyc, hs_cyc, vs_cyc, fs_cyc, de_cnt;
  logic prev_hs, prev_vs;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    mh = 0; mv = 0; e_ph = -1; e_pv = -1;
    e_de = 1'b0; e_hs = 1'b0; e_vs = 1'b0; e_ls = 1'b0; e_fs = 1'b0; e_fen = 1'b0;
    e_x = 0; e_y = 0; e_fx = 0; e_fy = 0;
  endtask

  task automatic model_step();
    int ha, row;
    e_ph = mh; e_pv = mv;
    e_de = (mh < HV) && (mv < VV);
    e_x  = e_de ? mh : 0;
    e_y  = e_de ? mv : 0;
    e_hs = (mh >= HV + HF) && (mh < HV + HF + HS);
    e_vs = (mv >= VV + VF) && (mv < VV + VF + VS);
    e_ls = (mh == 0) && (mv < VV);
    e_fs = (mh == 0) && (mv == 0);
    ha = mh + 2; row = mv;
    if (ha >= HT) begin
      ha  = ha - HT;
      row = (mv == VT - 1) ? 0 : mv + 1;
    end
    e_fen = (ha < HV) && (row < VV);
    e_fx  = e_fen ? ha : 0;
    e_fy  = e_fen ? row : 0;
    if (mh == HT - 1) begin
      mh = 0;
      mv = (mv == VT - 1) ? 0 : mv + 1;
    end else begin
      mh = mh + 1;
    end
  endtask

  task automatic meas_start(input int div);
    meas_on = 1'b1; meas_div = div;
    ls_seen = 1'b0; hs_seen = 1'b0; vs_seen = 1'b0; fs_seen = 1'b0;
    ls_cyc = 0; hs_cyc = 0; vs_cyc = 0; fs_cyc = 0; de_cnt = 0;
    prev_hs = 1'b1; prev_vs = 1'b1;
  endtask

  task automatic check_all();
    chk("a_hsync",       32'(vid_a.hsync),       32'(!e_hs));
    chk("a_vsync",       32'(vid_a.vsync),       32'(!e_vs));
    chk("a_display_en",  32'(vid_a.display_en),  32'(e_de));
    chk("a_x",           32'(vid_a.x),           e_x);
    chk("a_y",           32'(vid_a.y),           e_y);
    chk("a_line_start",  32'(vid_a.line_start),  32'(e_ls));
    chk("a_frame_start", 32'(vid_a.frame_start), 32'(e_fs));
    chk("a_fetch_en",    32'(vid_a.fetch_en),    32'(e_fen));
    chk("a_fetch_x",     32'(vid_a.fetch_x),     e_fx);
    chk("a_fetch_y",     32'(vid_a.fetch_y),     e_fy);
    chk("b_hsync",       32'(vid_b.hsync),       32'(e_hs));
    chk("b_vsync",       32'(vid_b.vsync),       32'(e_vs));
    chk("b_display_en",  32'(vid_b.display_en),  32'(e_de));
    chk("b_xy",          {16'(vid_b.x), 16'(vid_b.y)}, {16'(e_x), 16'(e_y)});
    chk("b_strobes",     {30'd0, vid_b.line_start, vid_b.frame_start}, {30'd0, e_ls, e_fs});
    chk("b_fetch_en",    32'(vid_b.fetch_en),    32'(e_de));
    chk("b_fetch_xy",    {16'(vid_b.fetch_x), 16'(vid_b.fetch_y)}, {16'(e_x), 16'(e_y)});

    // look-ahead corners: last line wraps to (0,0); line 3 h=6 points past the visible area
    if (e_ph == HT - 2 && e_pv == VT - 1) begin
      chk("la_wrap_en", 32'(vid_a.fetch_en), 1);
      chk("la_wrap_x",  32'(vid_a.fetch_x),  0);
      chk("la_wrap_y",  32'(vid_a.fetch_y),  0);
    end
    if (e_ph == 6 && e_pv == 3)
      chk("la_l3_h6_en", 32'(vid_a.fetch_en), 0);

    if (meas_on) begin
      if (vid_a.line_start) begin
        ls_seen = 1'b1; ls_cyc = cyc; de_cnt = 0;
      end
      if (vid_a.display_en) de_cnt++;
      if (prev_hs && !vid_a.hsync) begin
        if (ls_seen && (cyc - ls_cyc) < HT * meas_div) begin
          chk("hs_offset",    cyc - ls_cyc, (HV + HF) * meas_div);
          chk("de_per_line",  de_cnt,       HV * meas_div);
        end
        hs_seen = 1'b1; hs_cyc = cyc;
      end
      if (!prev_hs && vid_a.hsync && hs_seen)
        chk("hs_width", cyc - hs_cyc, HS * meas_div);
      if (prev_vs && !vid_a.vsync) begin
        vs_seen = 1'b1; vs_cyc = cyc;
      end
      if (!prev_vs && vid_a.vsync && vs_seen)
        chk("vs_width", cyc - vs_cyc, VS * HT * meas_div);
      if (vid_a.frame_start) begin
        if (fs_seen) chk("frame_period", cyc - fs_cyc, HT * VT * meas_div);
        fs_seen = 1'b1; fs_cyc = cyc;
      end
      prev_hs = vid_a.hsync;
      prev_vs = vid_a.vsync;
    end
  endtask

  // called at a falling edge: drive pix_ce, let one rising edge pass, check
  task automatic tick(input logic ce);
    pix_ce = ce;
    @(posedge clk);
    if (!rst_n)  model_reset();
    else if (ce) model_step();
    else begin
      e_ls = 1'b0;
      e_fs = 1'b0;
    end
    @(negedge clk);
    cyc++;
    check_all();
  endtask

  initial begin
    bit found;
    rst_n   = 1'b0;
    pix_ce  = 1'b1;
    meas_on = 1'b0;
    model_reset();
    @(negedge clk);
    repeat (3) tick(1'b1);

    chk("rst_a_hsync",   32'(vid_a.hsync), 1);
    chk("rst_a_vsync",   32'(vid_a.vsync), 1);
    chk("rst_b_syncs",   {30'd0, vid_b.hsync, vid_b.vsync}, 0);
    chk("rst_a_de",      32'(vid_a.display_en), 0);
    chk("rst_a_xy",      {16'(vid_a.x), 16'(vid_a.y)}, 0);
    chk("rst_a_strobes", {30'd0, vid_a.line_start, vid_a.frame_start}, 0);
    chk("rst_a_fetch",   {vid_a.fetch_en, 16'(vid_a.fetch_x), 15'(vid_a.fetch_y)}, 0);

    // release; first tick presents (0,0)
    rst_n = 1'b1;
    meas_start(1);
    tick(1'b1);
    chk("first_frame_start", 32'(vid_a.frame_start), 1);
    chk("first_line_start",  32'(vid_a.line_start),  1);
    chk("first_de",          32'(vid_a.display_en),  1);
    chk("first_xy",          {16'(vid_a.x), 16'(vid_a.y)}, 0);
    repeat (3 * HT * VT) tick(1'b1);

    // one pixel tick every four clocks
    meas_start(4);
    for (int i = 0; i < 3 * HT * VT * 4 + 8; i++) tick((i % 4) == 0);

    // reset in the middle of a visible line
    meas_on = 1'b0;
    found   = 1'b0;
    for (int i = 0; i < 2 * HT * VT && !found; i++) begin
      tick(1'b1);
      if (e_ph == 5 && e_pv == 2) found = 1'b1;
    end
    chk("midframe_reached", 32'(found), 1);
    chk("midframe_x", 32'(vid_a.x), 5);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_de",    32'(vid_a.display_en), 0);
    chk("async_rst_xy",    {16'(vid_a.x), 16'(vid_a.y)}, 0);
    chk("async_rst_hsync", 32'(vid_a.hsync), 1);
    chk("async_rst_fetch", 32'(vid_a.fetch_en), 0);
    model_reset();
    repeat (3) tick(1'b1);
    rst_n = 1'b1;
    meas_start(1);
    tick(1'b1);
    chk("restart_frame_start", 32'(vid_a.frame_start), 1);
    chk("restart_xy",          {16'(vid_a.x), 16'(vid_a.y)}, 0);
    repeat (HT * VT + 40) tick(1'b1);
    chk("restart_period_seen", 32'(fs_seen && (fs_cyc - cyc) != 0), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
